reg_file_sb: RTL and testbench

Parametrised multi-read-port integer register file for the pipelined RISC-V core, with write-through bypass and an integrated busy-bit scoreboard. Decode reads operands and per-operand busy flags. Issue marks destination registers pending. Writeback updates data and clears pending. A debug read port replaces the fixed a0 tap used by the single-cycle testbenches.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/reg_file_sb_scoreboard.sv | 64 ++++++
 rtl/reg_file_sb.sv | 92 +++++++++
 tb/tb_reg_file_sb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the integer register file and its
// busy-bit scoreboard.
//   XLEN_DEFAULT  : default data width of a register
//   NREGS_DEFAULT : default number of architectural registers
//   REG_ZERO      : index of the hardwired-zero register (x0)
//   reg_addr_t    : register address type for the default configuration
//   xlen_t        : register data type for the default configuration
// ---------------------------------------------------------------------------
package rf_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;
   localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);
   localparam int REG_ZERO      = 0;

   typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
   typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// One pending ("busy") bit per architectural register. Issue marks the
// destination pending, writeback clears it, flush clears everything.
// Register 0 is never pending.
// Ports:
//   clk            : clock, state updates on rising edge
//   rst_n          : asynchronous active-low reset, clears all busy bits
//   issue_valid_i  : an instruction with a destination issued this cycle
//   issue_rd_i     : destination of the issued instruction
//   we_i           : writeback enable
//   wa_i           : writeback address
//   flush_i        : pipeline flush, clears all busy bits
//   busy_vec_o     : current scoreboard state, bit k = register k pending
// ---------------------------------------------------------------------------
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS = NREGS_DEFAULT,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid_i,
   input  logic [AW-1:0]    issue_rd_i,
   input  logic             we_i,
   input  logic [AW-1:0]    wa_i,
   input  logic             flush_i,
   output logic [NREGS-1:0] busy_vec_o
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Next-state priority per register: flush clears everything, otherwise a
   // new producer (issue) wins over a retiring one (writeback) on the same
   // register because the issue is applied last. x0 is forced clear.
   always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = '0;
      end else begin
         if (we_i && (wa_i != AW'(REG_ZERO))) begin
            busy_d[wa_i] = 1'b0;
         end
         if (issue_valid_i && (issue_rd_i != AW'(REG_ZERO))) begin
            busy_d[issue_rd_i] = 1'b1;
         end
      end
      busy_d[REG_ZERO] = 1'b0;
   end

   // Scoreboard state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Multi-read-port integer register file with write-through bypass and an
// integrated busy-bit scoreboard. Reads are combinational; a read of the
// register being written this cycle returns the new data. x0 reads as zero,
// is never written and is never busy.
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   rs_addr      : packed read addresses, port i at [i*AW +: AW]
//   rs_data      : packed read data, port i at [i*XLEN +: XLEN]
//   rs_busy      : per-port pending flag of the addressed register
//   we, wa, wd   : writeback enable, address, data
//   issue_valid  : instruction with destination issued this cycle
//   issue_rd     : destination register of the issued instruction
//   flush        : clears all busy bits
//   dbg_addr     : debug read address
//   dbg_data     : debug read data, registered value only (no bypass)
//   busy_vec     : full scoreboard state
// ---------------------------------------------------------------------------
module reg_file_sb
   import rf_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int NREGS = NREGS_DEFAULT,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_busy,
   input  logic                we,
   input  logic [AW-1:0]       wa,
   input  logic [XLEN-1:0]     wd,
   input  logic                issue_valid,
   input  logic [AW-1:0]       issue_rd,
   input  logic                flush,
   input  logic [AW-1:0]       dbg_addr,
   output logic [XLEN-1:0]     dbg_data,
   output logic [NREGS-1:0]    busy_vec
);

   logic [XLEN-1:0] regFile_q [NREGS];
   logic            writeValid;

   assign writeValid = we && (wa != AW'(REG_ZERO));

   // Register storage. x0 is cleared on reset and never written, so reads
   // of it naturally return zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREGS; k++) begin
            regFile_q[k] <= '0;
         end
      end else if (writeValid) begin
         regFile_q[wa] <= wd;
      end
   end

   rf_scoreboard #(
      .NREGS(NREGS)
   ) uScoreboard (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .we_i          (we),
      .wa_i          (wa),
      .flush_i       (flush),
      .busy_vec_o    (busy_vec)
   );

   // Per-port read mux with write-through bypass. The busy flag is dropped
   // when this cycle's writeback retires the register, unless an issue in
   // the same cycle re-marks it; in that case the current state is shown.
   for (genvar i = 0; i < NRD; i++) begin : gReadPort
      logic [AW-1:0] rdAddr;
      logic          bypassHit;
      logic          reissueHit;

      assign rdAddr     = rs_addr[i*AW +: AW];
      assign bypassHit  = writeValid && (wa == rdAddr);
      assign reissueHit = issue_valid && (issue_rd == rdAddr);

      assign rs_data[i*XLEN +: XLEN] = bypassHit ? wd : regFile_q[rdAddr];
      assign rs_busy[i] = busy_vec[rdAddr] && !(bypassHit && !reissueHit);
   end

   assign dbg_data = regFile_q[dbg_addr];

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Randomised and directed bench for reg_file_sb. A behavioural model of the
// register contents and pending bits is updated once per rising edge and all
// DUT outputs are compared against it in the middle of each cycle.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

   parameter int NRD    = 2;
   parameter int NREGS  = 32;
   localparam int XLEN  = 32;
   localparam int AW    = $clog2(NREGS);

   logic                clk;
   logic                rst_n;
   logic [NRD*AW-1:0]   rs_addr;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NRD-1:0]      rs_busy;
   logic                we;
   logic [AW-1:0]       wa;
   logic [XLEN-1:0]     wd;
   logic                issue_valid;
   logic [AW-1:0]       issue_rd;
   logic                flush;
   logic [AW-1:0]       dbg_addr;
   logic [XLEN-1:0]     dbg_data;
   logic [NREGS-1:0]    busy_vec;

   // Reference state: plain arrays of values and pending flags.
   logic [XLEN-1:0] refMem [NREGS];
   bit              refBusy [NREGS];

   int total = 0;
   int bad   = 0;

   reg_file_sb #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NRD   (NRD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rs_addr     (rs_addr),
      .rs_data     (rs_data),
      .rs_busy     (rs_busy),
      .we          (we),
      .wa          (wa),
      .wd          (wd),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .flush       (flush),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data),
      .busy_vec    (busy_vec)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives the write/issue/flush controls for the current cycle.
   task automatic applyStimulus(input logic w, input int a, input logic [XLEN-1:0] d,
                                input logic iv, input int ird, input logic fl);
      we          = w;
      wa          = AW'(a);
      wd          = d;
      issue_valid = iv;
      issue_rd    = AW'(ird);
      flush       = fl;
   endtask

   task automatic setPort(input int p, input int a);
      rs_addr[p*AW +: AW] = AW'(a);
   endtask

   function automatic logic [XLEN-1:0] portData(input int p);
      return rs_data[p*XLEN +: XLEN];
   endfunction

   // Expected read value: x0 is zero, a same-cycle write is seen, otherwise
   // the stored value.
   function automatic logic [XLEN-1:0] expData(input int a);
      if (a == 0) return '0;
      if (we && int'(wa) == a) return wd;
      return refMem[a];
   endfunction

   // Expected busy flag: current pending bit, hidden by a retiring write
   // unless an issue to the same register happens in the same cycle.
   function automatic logic expBusy(input int a);
      if (a == 0) return 1'b0;
      if (we && int'(wa) == a && !(issue_valid && int'(issue_rd) == a)) return 1'b0;
      return refBusy[a];
   endfunction

   function automatic logic [NREGS-1:0] expBusyVec();
      logic [NREGS-1:0] v;
      v = '0;
      for (int k = 0; k < NREGS; k++) v[k] = refBusy[k];
      return v;
   endfunction

   // Compares every output of the DUT against the model.
   task automatic checkAll(input string tag);
      for (int p = 0; p < NRD; p++) begin
         int a;
         a = int'(rs_addr[p*AW +: AW]);
         checkOutput($sformatf("%s.data%0d", tag, p), 64'(portData(p)), 64'(expData(a)));
         checkOutput($sformatf("%s.busy%0d", tag, p), 64'(rs_busy[p]), 64'(expBusy(a)));
      end
      checkOutput({tag, ".busyVec"}, 64'(busy_vec), 64'(expBusyVec()));
      checkOutput({tag, ".dbg"}, 64'(dbg_data), 64'(refMem[int'(dbg_addr)]));
   endtask

   task automatic modelReset();
      for (int k = 0; k < NREGS; k++) begin
         refMem[k]  = '0;
         refBusy[k] = 1'b0;
      end
   endtask

   // Applies one rising edge to the model from the current inputs.
   task automatic modelClock();
      if (we && wa != '0) refMem[int'(wa)] = wd;
      for (int k = 1; k < NREGS; k++) begin
         if (flush) refBusy[k] = 1'b0;
         else if (issue_valid && int'(issue_rd) == k) refBusy[k] = 1'b1;
         else if (we && int'(wa) == k) refBusy[k] = 1'b0;
      end
      refBusy[0] = 1'b0;
   endtask

   // Advances one cycle: DUT and model both see the rising edge, then the
   // bench returns to the falling edge to drive the next cycle.
   task automatic tick();
      @(posedge clk);
      modelClock();
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      logic [XLEN-1:0] rnd;
      modelReset();
      rst_n    = 1'b0;
      rs_addr  = '0;
      dbg_addr = '0;
      idle();

      // Reset: sweep all addresses while reset is held, then release.
      for (int a = 0; a < NREGS; a++) begin
         #2;
         setPort(0, a);
         setPort(NRD - 1, NREGS - 1 - a);
         dbg_addr = AW'(a);
         #1 checkAll("reset");
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1 checkAll("postReset");
      tick();

      // Write with bypass: new value visible on the read port, old on debug.
      applyStimulus(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0);
      setPort(0, 5);
      dbg_addr = AW'(5);
      #1 checkAll("wrBypass");
      checkOutput("wrBypassConst", 64'(portData(0)), 64'h0000_0000_DEAD_BEEF);
      checkOutput("dbgOldConst", 64'(dbg_data), 64'h0);
      tick();
      idle();
      #1 checkOutput("dbgNewConst", 64'(dbg_data), 64'h0000_0000_DEAD_BEEF);
      checkAll("wrRead");
      tick();
      applyStimulus(1'b1, 5, '0, 1'b0, 0, 1'b0);
      #1 checkAll("wrZeroBypass");
      tick();
      idle();
      #1 checkAll("wrZero");
      checkOutput("wrZeroConst", 64'(dbg_data), 64'h0);
      tick();

      // x0: writes and issues to register 0 have no effect.
      applyStimulus(1'b1, 0, 32'h1234, 1'b1, 0, 1'b0);
      setPort(0, 0);
      setPort(NRD - 1, 0);
      dbg_addr = '0;
      #1 checkAll("x0Same");
      checkOutput("x0DataConst", 64'(portData(0)), 64'h0);
      tick();
      idle();
      for (int c = 0; c < 2; c++) begin
         #1 checkAll("x0After");
         checkOutput("x0BusyConst", 64'(busy_vec[0]), 64'h0);
         tick();
      end

      // Scoreboard: issue x7, see it pending, retire it three cycles later.
      applyStimulus(1'b0, 0, '0, 1'b1, 7, 1'b0);
      setPort(0, 7);
      #1 checkAll("sbIssue");
      tick();
      idle();
      #1 checkAll("sbPend1");
      checkOutput("sbPendConst", 64'(busy_vec[7]), 64'h1);
      checkOutput("sbRsBusyConst", 64'(rs_busy[0]), 64'h1);
      tick();
      #1 checkAll("sbPend2");
      tick();
      applyStimulus(1'b1, 7, 32'hA5A5_0007, 1'b0, 0, 1'b0);
      #1 checkAll("sbRetire");
      checkOutput("sbRetireBusyConst", 64'(rs_busy[0]), 64'h0);
      checkOutput("sbRetireDataConst", 64'(portData(0)), 64'h0000_0000_A5A5_0007);
      tick();
      idle();
      #1 checkAll("sbCleared");
      checkOutput("sbClearedConst", 64'(busy_vec[7]), 64'h0);
      tick();

      // Simultaneous issue and writeback on a busy register, then with flush.
      applyStimulus(1'b0, 0, '0, 1'b1, 9, 1'b0);
      setPort(0, 9);
      dbg_addr = AW'(9);
      tick();
      applyStimulus(1'b1, 9, 32'h0000_0909, 1'b1, 9, 1'b0);
      #1 checkAll("simulIssueWb");
      tick();
      idle();
      #1 checkAll("simulAfter");
      checkOutput("simulBusyConst", 64'(busy_vec[9]), 64'h1);
      checkOutput("simulDataConst", 64'(dbg_data), 64'h0000_0000_0000_0909);
      applyStimulus(1'b1, 9, 32'h0000_1919, 1'b1, 9, 1'b1);
      #1 checkAll("flushSame");
      tick();
      idle();
      #1 checkAll("flushAfter");
      checkOutput("flushVecConst", 64'(busy_vec), 64'h0);
      checkOutput("flushDataConst", 64'(dbg_data), 64'h0000_0000_0000_1919);
      tick();

      // Asynchronous reset between edges with a write pending.
      applyStimulus(1'b0, 0, '0, 1'b1, 3, 1'b0);
      tick();
      applyStimulus(1'b0, 0, '0, 1'b1, 4, 1'b0);
      tick();
      applyStimulus(1'b1, 3, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
      setPort(0, 3);
      setPort(NRD - 1, 4);
      dbg_addr = AW'(9);
      #1 checkAll("preAsync");
      rst_n = 1'b0;
      modelReset();
      #1 checkAll("asyncReset");
      checkOutput("asyncVecConst", 64'(busy_vec), 64'h0);
      checkOutput("asyncDbgConst", 64'(dbg_data), 64'h0);
      idle();
      #1 rst_n = 1'b1;
      tick();
      #1 checkAll("asyncLost");
      checkOutput("asyncLostConst", 64'(portData(0)), 64'h0);

      // Randomised traffic against the model.
      for (int c = 0; c < 400; c++) begin
         rnd = $urandom;
         if ($urandom_range(0, 3) == 0) rnd = '0;
         applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)), rnd,
                       1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)),
                       1'($urandom_range(0, 15) == 0));
         for (int p = 0; p < NRD; p++) begin
            if ($urandom_range(0, 3) == 0) setPort(p, int'(wa));
            else if ($urandom_range(0, 3) == 0) setPort(p, int'(issue_rd));
            else setPort(p, int'($urandom_range(0, NREGS - 1)));
         end
         dbg_addr = AW'($urandom_range(0, NREGS - 1));
         #1 checkAll("rand");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
